bp_dma_channel_arbiter: RTL
===========================

# bp_dma_channel_arbiter

Shares one DRAM DMA channel (bsg_cache DMA packet, write-data and read-data streams) among `num_req_p` L2 bank DMA ports of the unicore complex. It sits between the per-core/per-bank `dma_pkt`/`dma_data` ports and a single memory controller port. It grants packets round-robin and locks the write-data stream to the granted writer for one block. It records the requester of each read in an order FIFO so that returning read beats are steered back in issue order.

## Interface
Parameters:
- `num_req_p`, 4: number of requesting DMA ports; must be ≥2.
- `daddr_width_p`, 28: DRAM address width.
- `fill_width_p`, 64: data beat width.
- `block_width_p`, 512: bytes-per-transfer × 8; `beats_lp = block_width_p/fill_width_p` (≥1, power of 2).
- `rd_fifo_els_p`, 4: maximum outstanding reads.

Packet layout: `pkt_width_lp = 1+daddr_width_p`. The MSB is write_not_read and the remaining bits are the address.

Ports:
- `clk_i`, in, 1: clock.
- `reset_n_i`, in, 1: asynchronous, active-low reset.
- `req_pkt_i`, in, `[num_req_p][pkt_width_lp]`: requester packets.
- `req_pkt_v_i`, in, `[num_req_p]`: packet valid.
- `req_pkt_ready_and_o`, out, `[num_req_p]`: packet accepted (one-hot or zero).
- `req_data_i`, in, `[num_req_p][fill_width_p]`: requester write beats.
- `req_data_v_i`, in, `[num_req_p]`: write beat valid.
- `req_data_ready_and_o`, out, `[num_req_p]`: write beat accepted.
- `req_data_o`, out, `[num_req_p][fill_width_p]`: read beats; the `dma_data_i` broadcast to all requesters.
- `req_data_v_o`, out, `[num_req_p]`: read beat valid (one-hot or zero).
- `req_data_ready_and_i`, in, `[num_req_p]`: read beat accepted.
- `dma_pkt_o`, out, `pkt_width_lp`: granted packet.
- `dma_pkt_v_o`, out, 1: packet valid.
- `dma_pkt_ready_and_i`, in, 1: controller accepts the packet.
- `dma_data_o`, out, `fill_width_p`: write beat to the controller.
- `dma_data_v_o`, out, 1: write beat valid.
- `dma_data_ready_and_i`, in, 1: controller accepts the write beat.
- `dma_data_i`, in, `fill_width_p`: read beat from the controller.
- `dma_data_v_i`, in, 1: read beat valid.
- `dma_data_ready_and_o`, out, 1: read beat accepted.

## Operation
- State machine: `e_arb` and `e_wdata`. Reset enters `e_arb`.
- Eligibility in `e_arb`:
  - A write request is eligible if `req_pkt_v_i[i]`.
  - A read request is eligible if `req_pkt_v_i[i]` and the order FIFO is not full.
- No request is eligible in `e_wdata`.
- Round-robin selection:
  - The winner is the first eligible index at or after `rr_ptr`, wrapping modulo `num_req_p`.
  - `dma_pkt_o` is the winner's packet, and `dma_pkt_v_o` = any eligible.
  - `req_pkt_ready_and_o[winner]` = `dma_pkt_ready_and_i`; all other bits are 0.
- On packet handshake:
  - `rr_ptr` ← winner+1 mod `num_req_p`.
  - Read: push the winner id into the order FIFO.
  - Write: record `wr_owner` ← winner, clear `wr_cnt`, go to `e_wdata`.
- `e_wdata`:
  - `dma_data_o`/`dma_data_v_o` come from `req_data_i`/`req_data_v_i[wr_owner]`.
  - `req_data_ready_and_o[wr_owner]` = `dma_data_ready_and_i`; all other bits are 0.
  - Each beat handshake increments `wr_cnt`.
  - On the handshake with `wr_cnt==beats_lp-1`, return to `e_arb`.
- Read return runs independently of the state machine:
  - With head id `h`, `req_data_v_o[h]` = `dma_data_v_i` & FIFO not empty.
  - `dma_data_ready_and_o` = FIFO not empty & `req_data_ready_and_i[h]`.
  - Each beat handshake increments `rd_cnt`; on the last beat, pop the FIFO and clear `rd_cnt`.
- A push and a pop in the same cycle are both performed; occupancy is unchanged. A push while full is impossible by construction.
- Read data arriving with the FIFO empty is never accepted (`dma_data_ready_and_o`=0).
- Counters are `$clog2(beats_lp)` bits wide, minimum 1 bit. They wrap only by explicit clear.

## Timing
- Packet path: 0-cycle combinational, input valid to `dma_pkt_v_o`.
- Data paths: 0-cycle combinational; no buffering inside the block.
- The round-robin pointer updates on the clock edge after the grant.
- The first write beat is forwarded in the cycle after the packet handshake.
- A new packet can be granted in the cycle after the last write beat.
- Back-to-back reads can be granted every cycle until the FIFO is full.
- The first returned read beat can be accepted in the cycle after its push.
- Reset (async assert):
  - State, `rr_ptr`, `wr_owner`, `wr_cnt`, `rd_cnt` and FIFO pointers are cleared.
  - All `*_v_o` and `*_ready_and_o` outputs read 0 while `reset_n_i`=0.
  - Reset mid-burst abandons the burst with no residual state.

## Test plan
- Reads from requesters 0–3 all valid in cycle 0, `dma_pkt_ready_and_i`=1 → grants in order 0,1,2,3 on consecutive cycles. Then with `rd_fifo_els_p`=4 the FIFO is full, and a further read from requester 0 is held until the first pop.
- Requester 2 issues a write with 8 beats (`beats_lp`=8), while requester 1 has a read pending → the 8 beats from requester 2 pass through while requester 1 sees ready=0. Requester 1 is granted in the cycle after beat 8.
- Read return for ids [3,0]: 16 beats on `dma_data_i` → beats 0–7 appear only on `req_data_v_o[3]`, beats 8–15 only on `req_data_v_o[0]`. Deassert `req_data_ready_and_i[3]` on beat 4 → `dma_data_ready_and_o`=0 that cycle.
- FIFO full with a write pending from requester 1 → the write is granted while all reads are blocked.
- `dma_data_v_i`=1 with the FIFO empty → `dma_data_ready_and_o` stays 0 and all `req_data_v_o` stay 0.
- Assert `reset_n_i`=0 during write beat 3 → outputs drop to 0 immediately. After release, state is `e_arb` with `rr_ptr`=0, and requester 0 wins a fresh arbitration.

Source files
------------

// File: rtl/bp_dma_channel_arbiter.sv
// rtl/bp_dma_channel_arbiter.sv - round-robin DMA channel arbiter with write-data lock and read-return order FIFO
module bp_dma_channel_arbiter #(
    parameter int num_req_p     = 4,
    parameter int daddr_width_p = 28,
    parameter int fill_width_p  = 64,
    parameter int block_width_p = 512,
    parameter int rd_fifo_els_p = 4
) (
    input  logic                                       clk_i,
    input  logic                                       reset_n_i,
    input  logic [num_req_p*(daddr_width_p+1)-1:0]     req_pkt_i,
    input  logic [num_req_p-1:0]                       req_pkt_v_i,
    output logic [num_req_p-1:0]                       req_pkt_ready_and_o,
    input  logic [num_req_p*fill_width_p-1:0]          req_data_i,
    input  logic [num_req_p-1:0]                       req_data_v_i,
    output logic [num_req_p-1:0]                       req_data_ready_and_o,
    output logic [num_req_p*fill_width_p-1:0]          req_data_o,
    output logic [num_req_p-1:0]                       req_data_v_o,
    input  logic [num_req_p-1:0]                       req_data_ready_and_i,
    output logic [daddr_width_p:0]                     dma_pkt_o,
    output logic                                       dma_pkt_v_o,
    input  logic                                       dma_pkt_ready_and_i,
    output logic [fill_width_p-1:0]                    dma_data_o,
    output logic                                       dma_data_v_o,
    input  logic                                       dma_data_ready_and_i,
    input  logic [fill_width_p-1:0]                    dma_data_i,
    input  logic                                       dma_data_v_i,
    output logic                                       dma_data_ready_and_o
);

    localparam int pkt_width_lp = daddr_width_p + 1;
    localparam int beats_lp     = block_width_p / fill_width_p;
    localparam int cnt_width_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;
    localparam int id_width_lp  = $clog2(num_req_p);
    localparam int ptr_width_lp = (rd_fifo_els_p > 1) ? $clog2(rd_fifo_els_p) : 1;
    localparam int occ_width_lp = $clog2(rd_fifo_els_p + 1);

    typedef enum logic {e_arb, e_wdata} state_e;

    state_e                  state_q, state_d;
    logic [id_width_lp-1:0]  rr_ptr_q, rr_ptr_d;
    logic [id_width_lp-1:0]  wr_owner_q, wr_owner_d;
    logic [cnt_width_lp-1:0] wr_cnt_q, wr_cnt_d;
    logic [cnt_width_lp-1:0] rd_cnt_q, rd_cnt_d;
    logic [ptr_width_lp-1:0] wr_ptr_q, wr_ptr_d;
    logic [ptr_width_lp-1:0] rd_ptr_q, rd_ptr_d;
    logic [occ_width_lp-1:0] occ_q, occ_d;
    logic [id_width_lp-1:0]  fifo_mem_q [rd_fifo_els_p];

    logic [num_req_p-1:0]    elig;
    logic [id_width_lp-1:0]  winner;
    logic [id_width_lp-1:0]  head_id;
    logic                    any_elig;
    logic                    winner_is_write;
    logic                    fifo_full, fifo_empty;
    logic                    pkt_hs, wbeat_hs, rbeat_hs;
    logic                    push, pop;
    logic                    wr_last, rd_last;
    int                      j;

    assign fifo_full  = (occ_q == occ_width_lp'(rd_fifo_els_p));
    assign fifo_empty = (occ_q == '0);

    // Reads are held off while the order FIFO cannot take another id.
    always_comb begin
        elig = '0;
        for (int i = 0; i < num_req_p; i++) begin
            elig[i] = (state_q == e_arb) && req_pkt_v_i[i]
                   && (req_pkt_i[i*pkt_width_lp + pkt_width_lp - 1] || !fifo_full);
        end
    end

    always_comb begin
        winner   = rr_ptr_q;
        any_elig = 1'b0;
        j        = 0;
        for (int k = 0; k < num_req_p; k++) begin
            j = int'(rr_ptr_q) + k;
            if (j >= num_req_p) j = j - num_req_p;
            if (!any_elig && elig[j]) begin
                any_elig = 1'b1;
                winner   = id_width_lp'(j);
            end
        end
    end

    assign dma_pkt_o       = req_pkt_i[winner*pkt_width_lp +: pkt_width_lp];
    assign winner_is_write = dma_pkt_o[pkt_width_lp-1];
    assign dma_pkt_v_o     = reset_n_i && any_elig;
    assign pkt_hs          = dma_pkt_v_o && dma_pkt_ready_and_i;

    always_comb begin
        req_pkt_ready_and_o = '0;
        if (reset_n_i && any_elig) req_pkt_ready_and_o[winner] = dma_pkt_ready_and_i;
    end

    assign dma_data_o   = req_data_i[wr_owner_q*fill_width_p +: fill_width_p];
    assign dma_data_v_o = reset_n_i && (state_q == e_wdata) && req_data_v_i[wr_owner_q];
    assign wbeat_hs     = dma_data_v_o && dma_data_ready_and_i;
    assign wr_last      = (wr_cnt_q == cnt_width_lp'(beats_lp - 1));

    always_comb begin
        req_data_ready_and_o = '0;
        if (reset_n_i && (state_q == e_wdata)) req_data_ready_and_o[wr_owner_q] = dma_data_ready_and_i;
    end

    // Read return follows the FIFO head regardless of the arbitration state.
    assign head_id              = fifo_mem_q[rd_ptr_q];
    assign req_data_o           = {num_req_p{dma_data_i}};
    assign dma_data_ready_and_o = reset_n_i && !fifo_empty && req_data_ready_and_i[head_id];
    assign rbeat_hs             = dma_data_v_i && dma_data_ready_and_o;
    assign rd_last              = (rd_cnt_q == cnt_width_lp'(beats_lp - 1));
    assign push                 = pkt_hs && !winner_is_write;
    assign pop                  = rbeat_hs && rd_last;

    always_comb begin
        req_data_v_o = '0;
        if (reset_n_i && !fifo_empty) req_data_v_o[head_id] = dma_data_v_i;
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        wr_owner_d = wr_owner_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        if (pkt_hs) begin
            rr_ptr_d = (winner == id_width_lp'(num_req_p - 1)) ? '0 : winner + 1'b1;
            if (winner_is_write) begin
                wr_owner_d = winner;
                wr_cnt_d   = '0;
                state_d    = e_wdata;
            end else begin
                wr_ptr_d = (wr_ptr_q == ptr_width_lp'(rd_fifo_els_p - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
        end
        if (wbeat_hs) begin
            if (wr_last) begin
                wr_cnt_d = '0;
                state_d  = e_arb;
            end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end
        if (rbeat_hs) begin
            if (rd_last) begin
                rd_cnt_d = '0;
                rd_ptr_d = (rd_ptr_q == ptr_width_lp'(rd_fifo_els_p - 1)) ? '0 : rd_ptr_q + 1'b1;
            end else begin
                rd_cnt_d = rd_cnt_q + 1'b1;
            end
        end
        if (push && !pop) occ_d = occ_q + 1'b1;
        else if (pop && !push) occ_d = occ_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= e_arb;
            rr_ptr_q   <= '0;
            wr_owner_q <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_owner_q <= wr_owner_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
        end
    end

    // Id storage needs no reset: entries are only read once the occupancy says they were written.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem_q[wr_ptr_q] <= winner;
    end

endmodule
